// File: rtl/sprite_programmer.sv
// Sprite-chain programming initiator: FIFO-buffered host updates replayed as framed
// program_active pulses during blanking. Optional id range filter: SPRITE_PROG_BOUNDS_EN.
module sprite_programmer #(
    parameter int FIFO_DEPTH  = 4,
    parameter int PULSE_LEN   = 2,
    parameter int NUM_SPRITES = 64
) (
    input  logic                          clk,
    input  logic                          clear,
    input  logic                          blank,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic [5:0]                    cmd_id,
    input  logic [7:0]                    cmd_x,
    input  logic [7:0]                    cmd_y,
    input  logic [15:0]                   cmd_addr,
    output logic [5:0]                    requested_sprite_id,
    output logic [7:0]                    setx,
    output logic [7:0]                    sety,
    output logic [15:0]                   set_address,
    output logic                          program_active,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic [7:0]                    reject_count
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int CNT_W = $clog2(PULSE_LEN + 1);

    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || PULSE_LEN < 1
        || NUM_SPRITES < 1 || NUM_SPRITES > 64) begin : g_bad_params
        $error("sprite_programmer: illegal parameter combination");
    end

    typedef enum logic [1:0] {IDLE, SETUP, PULSE, HOLD} state_t;

    typedef struct packed {
        logic [5:0]  id;
        logic [7:0]  x;
        logic [7:0]  y;
        logic [15:0] addr;
    } cmd_t;

    cmd_t             mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    state_t           state_q, state_d;
    cmd_t             bus_q, bus_d;
    logic             pa_q, pa_d;
    logic             busy_q, busy_d;
    logic             full, accept, wr_en, pop;
    cmd_t             cmd_in;

    assign cmd_in = '{id: cmd_id, x: cmd_x, y: cmd_y, addr: cmd_addr};

    // Readiness looks only at registered occupancy; a same-cycle pop never frees a slot.
    assign full      = (level_q == LVL_W'(FIFO_DEPTH));
    assign cmd_ready = !clear && !full;
    assign accept    = cmd_valid && cmd_ready;
    assign pop       = (state_q == IDLE) && (level_q != '0) && blank;

`ifdef SPRITE_PROG_BOUNDS_EN
    logic       in_range;
    logic [7:0] reject_q, reject_d;
    assign in_range = ({1'b0, cmd_id} < 7'(NUM_SPRITES));
    assign wr_en    = accept && in_range;
    assign reject_d = (accept && !in_range && reject_q != 8'hFF) ? reject_q + 8'd1 : reject_q;

    always_ff @(posedge clk or posedge clear) begin
        if (clear) reject_q <= '0;
        else       reject_q <= reject_d;
    end
    assign reject_count = reject_q;
`else
    assign wr_en        = accept;
    assign reject_count = '0;
`endif

    always_comb begin
        wr_ptr_d = wr_en ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop   ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        level_d  = level_q;
        case ({wr_en, pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bus_d   = bus_q;
        pa_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (pop) begin
                    bus_d   = mem_q[rd_ptr_q];
                    state_d = SETUP;
                end
            end
            SETUP: begin
                state_d = PULSE;
                pa_d    = 1'b1;
                cnt_d   = CNT_W'(PULSE_LEN - 1);
            end
            PULSE: begin
                // cnt_q counts the remaining high cycles after the current one
                if (cnt_q == '0) begin
                    state_d = HOLD;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                    pa_d  = 1'b1;
                end
            end
            HOLD:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            state_q  <= IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            cnt_q    <= '0;
            bus_q    <= '0;
            pa_q     <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            cnt_q    <= cnt_d;
            bus_q    <= bus_d;
            pa_q     <= pa_d;
            busy_q   <= busy_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q] <= cmd_in;
    end

    assign requested_sprite_id = bus_q.id;
    assign setx                = bus_q.x;
    assign sety                = bus_q.y;
    assign set_address         = bus_q.addr;
    assign program_active      = pa_q;
    assign busy                = busy_q;
    assign fifo_level          = level_q;

endmodule
